// File: rtl/mem_ctrl_mmio.sv
// A/D/M register and data-memory controller with a uniform-latency M read handshake
// and an MMIO window. Optional write-through forwarding: MEMCTRL_WR_FORWARD_EN.
module mem_ctrl_mmio #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                BRAM_LAT  = 1,
    parameter logic [DATA_W-1:0] PC_ADDR   = 16'h0001,
    parameter logic [DATA_W-1:0] MMIO_BASE = 16'h4000,
    parameter int                NUM_MMIO  = 4
) (
    input  logic                       wrbk_clk,
    input  logic                       rst,
    input  logic                       reg_a_en,
    input  logic                       reg_d_en,
    input  logic                       reg_m_en,
    input  logic [DATA_W-1:0]          data_in,
    input  logic [DATA_W-1:0]          program_counter,
    output logic [DATA_W-1:0]          reg_a_out,
    output logic [DATA_W-1:0]          reg_d_out,
    output logic [DATA_W-1:0]          reg_m_out,
    output logic                       m_valid,
    output logic                       stall,
    input  logic [DATA_W-1:0]          bram_douta,
    output logic                       bram_wea,
    output logic [DATA_W-1:0]          bram_dina,
    output logic [ADDR_W-1:0]          bram_addra,
    output logic [NUM_MMIO*DATA_W-1:0] mmio_regs,
    output logic [NUM_MMIO-1:0]        mmio_wr
);
    localparam int CNT_W = 3;
    localparam int IDX_W = (NUM_MMIO > 1) ? $clog2(NUM_MMIO) : 1;

    typedef enum logic { FETCH, VALID } state_t;
    typedef enum logic [1:0] { TGT_BRAM, TGT_PC, TGT_MMIO } tgt_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d, d_q, d_d, m_q, m_d, dina_q, dina_d;
    logic                valid_q, valid_d, wea_q, wea_d, addr_pend_q, addr_pend_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [DATA_W-1:0]   mmio_q [NUM_MMIO];
    logic [DATA_W-1:0]   mmio_d [NUM_MMIO];
    logic [NUM_MMIO-1:0] mmio_wr_q, mmio_wr_d;

    // Window end is one bit wider so a bank at the top of the space cannot wrap to 0.
    logic [DATA_W:0]   mmio_end;
    logic [IDX_W-1:0]  idx;
    tgt_t              tgt;
    logic [DATA_W-1:0] src;

    assign mmio_end = {1'b0, MMIO_BASE} + (DATA_W+1)'(NUM_MMIO);
    assign idx      = IDX_W'(a_q - MMIO_BASE);

    always_comb begin
        if (a_q == PC_ADDR)
            tgt = TGT_PC;
        else if (a_q >= MMIO_BASE && {1'b0, a_q} < mmio_end)
            tgt = TGT_MMIO;
        else
            tgt = TGT_BRAM;
        case (tgt)
            TGT_PC:   src = program_counter;
            TGT_MMIO: src = mmio_q[idx];
            default:  src = bram_douta;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q (or idle value) so no path leaves a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        d_d         = d_q;
        m_d         = m_q;
        valid_d     = valid_q;
        dina_d      = dina_q;
        addra_d     = addra_q;
        mmio_d      = mmio_q;
        wea_d       = 1'b0;
        mmio_wr_d   = '0;
        addr_pend_d = 1'b0;

        if (reg_d_en)
            d_d = data_in;

        if (state_q == FETCH) begin
            if (cnt_q == CNT_W'(1)) begin
                m_d     = src;
                valid_d = 1'b1;
                state_d = VALID;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (!(tgt == TGT_BRAM && wea_q)) begin
            // Hold one cycle while a BRAM write lands, so the pre-write word is not resampled.
            m_d = src;
        end

        // A BRAM write that coincided with an A load kept the old address; move on now.
        if (addr_pend_q)
            addra_d = a_q[ADDR_W-1:0];

        if (reg_m_en) begin
            case (tgt)
                TGT_BRAM: begin
                    wea_d  = 1'b1;
                    dina_d = data_in;
                end
                TGT_MMIO: begin
                    mmio_d[idx]    = data_in;
                    mmio_wr_d[idx] = 1'b1;
                end
                default: ;
            endcase
`ifdef MEMCTRL_WR_FORWARD_EN
            if (tgt != TGT_PC && !reg_a_en) begin
                m_d     = data_in;
                valid_d = 1'b1;
                state_d = VALID;
            end
`else
            valid_d = 1'b0;
            state_d = FETCH;
            cnt_d   = CNT_W'(BRAM_LAT);
`endif
        end

        if (reg_a_en) begin
            a_d     = data_in;
            valid_d = 1'b0;
            state_d = FETCH;
            cnt_d   = CNT_W'(BRAM_LAT);
            if (reg_m_en && tgt == TGT_BRAM)
                addr_pend_d = 1'b1;
            else
                addra_d = data_in[ADDR_W-1:0];
        end
    end

    always_ff @(posedge wrbk_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q     <= FETCH;
            cnt_q       <= CNT_W'(BRAM_LAT);
            a_q         <= '0;
            d_q         <= '0;
            m_q         <= '0;
            valid_q     <= 1'b0;
            wea_q       <= 1'b0;
            dina_q      <= '0;
            addra_q     <= '0;
            addr_pend_q <= 1'b0;
            mmio_wr_q   <= '0;
            // NOTE: the MMIO bank is a handful of flops, not RAM, so it is reset like any register.
            for (int i = 0; i < NUM_MMIO; i++)
                mmio_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            d_q         <= d_d;
            m_q         <= m_d;
            valid_q     <= valid_d;
            wea_q       <= wea_d;
            dina_q      <= dina_d;
            addra_q     <= addra_d;
            addr_pend_q <= addr_pend_d;
            mmio_wr_q   <= mmio_wr_d;
            mmio_q      <= mmio_d;
        end
    end

    for (genvar i = 0; i < NUM_MMIO; i++) begin : g_mmio
        assign mmio_regs[i*DATA_W +: DATA_W] = mmio_q[i];
    end

    assign reg_a_out  = a_q;
    assign reg_d_out  = d_q;
    assign reg_m_out  = m_q;
    assign m_valid    = valid_q;
    assign stall      = !valid_q;
    assign bram_wea   = wea_q;
    assign bram_dina  = dina_q;
    assign bram_addra = addra_q;
    assign mmio_wr    = mmio_wr_q;
endmodule
